fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that merges NUM_REQ burst write streams onto one FIFO
//   write port. A requester holds the port from its grant until it sends a
//   beat marked last or until MAX_BURST beats have transferred. One IDLE cycle
//   always separates consecutive grants.
//
// Ports
//   clk             : single clock, rising edge
//   rst             : asynchronous, active-high reset
//   req_data_in     : requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid_in    : per-requester valid
//   req_last_in     : per-requester last-beat marker
//   req_ready_out   : per-requester ready (only the granted one can be high)
//   fifo_data_out   : data to FIFO write side (zero when idle)
//   fifo_valid_out  : write valid to FIFO
//   fifo_ready_in   : FIFO not full
//   grant_out       : one-hot current grant, zero when idle
//   busy_out        : high while a grant is active
//   grant_count_out : (FIFO_ARB_STATS_EN only) per-requester 16-bit count of
//                     completed grants, requester i at [i*16 +: 16], wrapping
//
// Build option
//   FIFO_ARB_STATS_EN : adds grant_count_out and the per-requester counters.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
   input  logic [NUM_REQ-1:0]            req_valid_in,
   input  logic [NUM_REQ-1:0]            req_last_in,
   output logic [NUM_REQ-1:0]            req_ready_out,
   output logic [DATA_WIDTH-1:0]         fifo_data_out,
   output logic                          fifo_valid_out,
   input  logic                          fifo_ready_in,
   output logic [NUM_REQ-1:0]            grant_out,
`ifdef FIFO_ARB_STATS_EN
   output logic [NUM_REQ*16-1:0]         grant_count_out,
`endif
   output logic                          busy_out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] r_last_grant;
   logic [7:0]       r_count;

   logic             w_pick_found;
   logic [IDX_W-1:0] w_pick_idx;
   logic [IDX_W-1:0] w_cand;
   logic             w_gvalid;
   logic             w_glast;
   logic             w_beat;
   logic             w_end;

   // Round-robin search: start one past the last grant and take the first
   // valid requester, wrapping around the requester list.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((32'(r_last_grant) + 32'(k)) % NUM_REQ);
         if (!w_pick_found && req_valid_in[w_cand]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   assign w_gvalid = req_valid_in[r_grant_idx];
   assign w_glast  = req_last_in[r_grant_idx];

   // Only beats that actually move count toward the burst limit.
   assign w_beat = (r_state == S_GRANT) && w_gvalid && fifo_ready_in;
   assign w_end  = w_beat && (w_glast || ((r_count + 8'd1) == 8'(MAX_BURST)));

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_IDLE) begin
         if (w_pick_found) w_state_nxt = S_GRANT;
      end else begin
         if (w_end) w_state_nxt = S_IDLE;
      end
   end

   // ---------------- grant / counter datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_idx  <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_count      <= 8'd0;
      end else begin
         if (r_state == S_IDLE && w_pick_found)
            r_grant_idx <= w_pick_idx;
         if (w_end) begin
            r_last_grant <= r_grant_idx;
            r_count      <= 8'd0;
         end else if (w_beat) begin
            r_count <= r_count + 8'd1;
         end
      end
   end

   // ---------------- outputs ----------------
   // Combinational from the registered grant so data/valid/ready pass
   // through with no added latency; everything is zero outside GRANT.
   always_comb begin
      fifo_data_out  = '0;
      fifo_valid_out = 1'b0;
      req_ready_out  = '0;
      grant_out      = '0;
      busy_out       = 1'b0;
      if (r_state == S_GRANT) begin
         busy_out       = 1'b1;
         fifo_valid_out = w_gvalid;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == r_grant_idx) begin
               grant_out[i]     = 1'b1;
               req_ready_out[i] = fifo_ready_in;
               fifo_data_out    = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] r_gcnt [NUM_REQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) r_gcnt[i] <= 16'd0;
      end else if (w_end) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (IDX_W'(i) == r_grant_idx) r_gcnt[i] <= r_gcnt[i] + 16'd1;
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
      assign grant_count_out[gi*16 +: 16] = r_gcnt[gi];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=8).
//   A vector table covers reset, a single-requester burst and round-robin
//   fairness; hand-written sequences cover the burst cap, backpressure,
//   reset mid-burst and (when built with FIFO_ARB_STATS_EN) grant counters.
//   Inputs change in the clock low phase, outputs are sampled 1 time unit
//   later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;

   logic              clk;
   logic              rst;
   logic [NR*DW-1:0]  din;
   logic [NR-1:0]     vld;
   logic [NR-1:0]     lst;
   logic [NR-1:0]     rdy_out;
   logic [DW-1:0]     fdata;
   logic              fvalid;
   logic              fready;
   logic [NR-1:0]     grant;
   logic              busy;
`ifdef FIFO_ARB_STATS_EN
   logic [NR*16-1:0]  gcnt;
`endif

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_data_in    (din),
      .req_valid_in   (vld),
      .req_last_in    (lst),
      .req_ready_out  (rdy_out),
      .fifo_data_out  (fdata),
      .fifo_valid_out (fvalid),
      .fifo_ready_in  (fready),
      .grant_out      (grant),
`ifdef FIFO_ARB_STATS_EN
      .grant_count_out(gcnt),
`endif
      .busy_out       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic           r;
      logic [NR-1:0]  v;
      logic [NR-1:0]  l;
      logic [NR*DW-1:0] d;
      logic [NR-1:0]  e_grant;
      logic [DW-1:0]  e_data;
   } vec_t;

   function automatic logic [NR*DW-1:0] mkd(input logic [31:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic vec_t mk(input logic r, input logic [NR-1:0] v, l,
                               input logic [NR*DW-1:0] d,
                               input logic [NR-1:0] eg, input logic [DW-1:0] ed);
      vec_t t;
      t.r = r; t.v = v; t.l = l; t.d = d; t.e_grant = eg; t.e_data = ed;
      return t;
   endfunction

   vec_t tbl [17];

   initial begin
      logic [NR*DW-1:0] fair_d;
      int sent, beats, stall;
      bit   ok;
      logic [NR-1:0] prev_g;
      int   bl[$];

      rst = 1'b1; din = '0; vld = '0; lst = '0; fready = 1'b1;

      // ---- table: reset, single requester burst, round-robin fairness ----
      fair_d = mkd(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      tbl[0]  = mk(1, 4'b0000, 4'b0000, '0,                        4'b0000, 32'h0);
      tbl[1]  = mk(0, 4'b0010, 4'b0000, mkd(0, 32'hA0, 0, 0),     4'b0000, 32'h0);
      tbl[2]  = mk(0, 4'b0010, 4'b0000, mkd(0, 32'hA0, 0, 0),     4'b0010, 32'hA0);
      tbl[3]  = mk(0, 4'b0010, 4'b0000, mkd(0, 32'hA1, 0, 0),     4'b0010, 32'hA1);
      tbl[4]  = mk(0, 4'b0010, 4'b0010, mkd(0, 32'hA2, 0, 0),     4'b0010, 32'hA2);
      tbl[5]  = mk(0, 4'b0000, 4'b0000, '0,                        4'b0000, 32'h0);
      tbl[6]  = mk(1, 4'b0000, 4'b0000, '0,                        4'b0000, 32'h0);
      tbl[7]  = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0000, 32'h0);
      tbl[8]  = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0001, 32'hB0);
      tbl[9]  = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0000, 32'h0);
      tbl[10] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0010, 32'hB1);
      tbl[11] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0000, 32'h0);
      tbl[12] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0100, 32'hB2);
      tbl[13] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0000, 32'h0);
      tbl[14] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b1000, 32'hB3);
      tbl[15] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0000, 32'h0);
      tbl[16] = mk(0, 4'b1111, 4'b1111, fair_d,                    4'b0001, 32'hB0);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         rst = tbl[i].r; vld = tbl[i].v; lst = tbl[i].l; din = tbl[i].d; fready = 1'b1;
         #1;
         check($sformatf("vec%0d_grant", i), grant,   tbl[i].e_grant);
         check($sformatf("vec%0d_ready", i), rdy_out, tbl[i].e_grant);
         check($sformatf("vec%0d_valid", i), fvalid,  |tbl[i].e_grant);
         check($sformatf("vec%0d_busy", i),  busy,    |tbl[i].e_grant);
         check($sformatf("vec%0d_data", i),  fdata,   tbl[i].e_data);
      end

      // ---- burst cap: req 2 streams 20 beats with no last ----
      @(negedge clk); rst = 1'b1; vld = '0; lst = '0; din = '0;
      @(negedge clk); rst = 1'b0;
      sent = 0; beats = 0; prev_g = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         vld = (sent < 20) ? 4'b0100 : 4'b0000;
         din[2*DW +: DW] = 32'(32'hC00 + sent);
         #1;
         if (fvalid && fready) begin
            check("cap_data", fdata, 32'(32'hC00 + sent));
            sent++; beats++;
         end
         if (grant == 4'b0000 && prev_g != 4'b0000) begin
            bl.push_back(beats); beats = 0;
         end
         prev_g = grant;
      end
      check("cap_ngrants", bl.size(), 2);
      if (bl.size() >= 2) begin
         check("cap_burst0", bl[0], 8);
         check("cap_burst1", bl[1], 8);
      end
      check("cap_burst2_beats", beats, 4);
      check("cap_burst2_held", grant, 4'b0100);

      // ---- backpressure: 5 stall cycles after beat 2 of 5 ----
      @(negedge clk); rst = 1'b1; vld = '0; lst = '0; din = '0; fready = 1'b1;
      @(negedge clk); rst = 1'b0;
      sent = 0; stall = 0; ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         vld = 4'b0001;
         lst = (sent == 4) ? 4'b0001 : 4'b0000;
         din[0 +: DW] = 32'(32'hD0 + sent);
         fready = !(sent == 2 && stall < 5);
         #1;
         if (!fready) begin
            stall++;
            check("bp_ready_low", rdy_out, 4'b0000);
            check("bp_valid",     fvalid,  1'b1);
            check("bp_data_held", fdata,   32'hD2);
            check("bp_grant",     grant,   4'b0001);
         end else if (fvalid) begin
            check("bp_beat_data", fdata, 32'(32'hD0 + sent));
            sent++;
         end
         if (grant == 4'b0000 && sent > 0) ok = 1'b1;
      end
      check("bp_burst_done", ok, 1'b1);
      check("bp_total_beats", sent, 5);
      check("bp_stall_cycles", stall, 5);

      // ---- reset mid-burst: req 3 granted, reset after beat 2 ----
      @(negedge clk); rst = 1'b1; vld = '0; lst = '0; din = '0; fready = 1'b1;
      @(negedge clk); rst = 1'b0;
      sent = 0;
      for (int c = 0; c < 20 && sent < 2; c++) begin
         @(negedge clk);
         vld = 4'b1000;
         din[3*DW +: DW] = 32'(32'hE0 + sent);
         #1;
         if (fvalid && fready) sent++;
      end
      check("rst_two_beats", sent, 2);
      @(negedge clk);
      din[3*DW +: DW] = 32'hE2;
      #1;
      check("rst_pre_grant", grant, 4'b1000);
      rst = 1'b1;
      #1;
      check("rst_grant", grant,   4'b0000);
      check("rst_valid", fvalid,  1'b0);
      check("rst_ready", rdy_out, 4'b0000);
      check("rst_busy",  busy,    1'b0);
      check("rst_data",  fdata,   32'h0);
      vld = 4'b1001;
      @(negedge clk); rst = 1'b0;
      #1;
      check("rst_idle_after", grant, 4'b0000);
      @(negedge clk);
      #1;
      check("rst_req0_wins", grant, 4'b0001);

`ifdef FIFO_ARB_STATS_EN
      // ---- stats: three grants to req 0, one to req 2 ----
      @(negedge clk); rst = 1'b1; vld = '0; lst = '0; din = '0; fready = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      check("stats_reset", gcnt, 64'h0);
      one_grant(0); one_grant(0); one_grant(2); one_grant(0);
      @(negedge clk);
      #1;
      check("stats_req0", gcnt[0*16 +: 16], 16'd3);
      check("stats_req1", gcnt[1*16 +: 16], 16'd0);
      check("stats_req2", gcnt[2*16 +: 16], 16'd1);
      check("stats_req3", gcnt[3*16 +: 16], 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

`ifdef FIFO_ARB_STATS_EN
   task automatic one_grant(input int idx);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         vld = 4'(1 << idx);
         lst = 4'(1 << idx);
         #1;
         if (fvalid && fready) done = 1'b1;
      end
      check($sformatf("stats_xfer%0d", idx), done, 1'b1);
      @(negedge clk);
      vld = '0; lst = '0;
   endtask
`endif

endmodule
